// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount one coin at a time (20/10/5/1) over a
// valid/ready handshake, tracking per-denomination stock and reporting shortfall.
module change_dispenser #(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] amount,
  input  logic       refill,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [4:0] coin_val,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [5:0] shortfall,
  output logic [3:0] remain10,
  output logic [3:0] remain1,
  output logic [3:0] stock_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAIL
  } state_t;

  // Index 0..3 maps to denominations 1/5/10/20, matching stock_empty bit order.
  localparam logic [4:0] DENOM [4] = '{5'd1, 5'd5, 5'd10, 5'd20};

  state_t             state_q, state_d;
  logic [5:0]         remain_q, remain_d;
  logic [5:0]         shortfall_q, shortfall_d;
  logic [4:0]         coin_val_q, coin_val_d;
  logic [1:0]         coin_idx_q, coin_idx_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];

  logic [3:0] fits;
  logic       pick_found;
  logic [1:0] pick_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_denom
    assign stock_empty[gi] = (stock_q[gi] == '0);
    assign fits[gi]        = (6'(DENOM[gi]) <= remain_q) && (stock_q[gi] != '0);
  end

  // Ascending scan so the largest fitting denomination wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (fits[i]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    shortfall_d = shortfall_q;
    coin_val_d  = coin_val_q;
    coin_idx_d  = coin_idx_q;
    for (int i = 0; i < 4; i++) begin
      stock_d[i] = stock_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shortfall_d = 6'd0;
          remain_d    = amount;
          state_d     = (amount != 6'd0) ? S_SELECT : S_DONE;
        end else if (refill) begin
          for (int i = 0; i < 4; i++) begin
            stock_d[i] = '1;
          end
        end
      end
      S_SELECT: begin
        if (remain_q == 6'd0) begin
          state_d = S_DONE;
        end else if (pick_found) begin
          coin_val_d = DENOM[pick_idx];
          coin_idx_d = pick_idx;
          state_d    = S_ISSUE;
        end else begin
          shortfall_d = remain_q;
          state_d     = S_FAIL;
        end
      end
      S_ISSUE: begin
        if (coin_ready) begin
          remain_d            = remain_q - 6'(coin_val_q);
          stock_d[coin_idx_q] = stock_q[coin_idx_q] - 1'b1;
          coin_val_d          = 5'd0;
          state_d             = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remain_q    <= 6'd0;
      shortfall_q <= 6'd0;
      coin_val_q  <= 5'd0;
      coin_idx_q  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      shortfall_q <= shortfall_d;
      coin_val_q  <= coin_val_d;
      coin_idx_q  <= coin_idx_d;
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  // coin_val_q is only non-zero while in ISSUE, so it doubles as the output.
  assign coin_valid = (state_q == S_ISSUE);
  assign coin_val   = coin_val_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign fail       = (state_q == S_FAIL);
  assign shortfall  = shortfall_q;
  assign remain10   = 4'(remain_q / 6'd10);
  assign remain1    = 4'(remain_q % 6'd10);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the expected
// coins and terminal event at each start; a monitor pops them as the DUT presents them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] amount = 6'd0;
  logic       refill = 1'b0;
  logic       coin_ready = 1'b0;
  logic       coin_valid;
  logic [4:0] coin_val;
  logic       busy, done, fail;
  logic [5:0] shortfall;
  logic [3:0] remain10, remain1, stock_empty;

  change_dispenser #(.STOCK_W(4), .INIT_STOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .refill(refill),
    .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_val(coin_val),
    .busy(busy), .done(done), .fail(fail), .shortfall(shortfall),
    .remain10(remain10), .remain1(remain1), .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  // kind: 0 = coin, 1 = done, 2 = fail
  typedef struct {
    int kind;
    int val;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stock_m [4];
  int   denom_m [4] = '{1, 5, 10, 20};
  int   ready_mode = 0;   // 0 high, 1 random, 2 low

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_empty();
    int e = 0;
    for (int i = 0; i < 4; i++) if (stock_m[i] == 0) e |= (1 << i);
    return e;
  endfunction

  // Greedy payout computed directly from the amount and the modelled stock.
  task automatic model_push(input int amt, output int n_coins);
    int rem = amt;
    int pick;
    n_coins = 0;
    while (rem > 0) begin
      pick = -1;
      for (int i = 0; i < 4; i++) if (denom_m[i] <= rem && stock_m[i] > 0) pick = i;
      if (pick < 0) break;
      sb.push_back('{0, denom_m[pick], rem});
      rem -= denom_m[pick];
      stock_m[pick]--;
      n_coins++;
    end
    if (rem == 0) sb.push_back('{1, 0, 0});
    else          sb.push_back('{2, rem, rem});
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       coin_ready = 1'b1;
      1:       coin_ready = 1'($urandom_range(0, 1));
      default: coin_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done && fail) chk("done_fail_exclusive", 1, 0);
      if (coin_valid) begin
        if (sb.size() == 0 || sb[0].kind != 0) begin
          chk("unexpected_coin", int'(coin_val), -1);
        end else begin
          e = sb[0];
          chk("coin_val", int'(coin_val), e.val);
          if (coin_ready) begin
            chk("remain10", int'(remain10), e.rem / 10);
            chk("remain1", int'(remain1), e.rem % 10);
            void'(sb.pop_front());
          end
        end
      end
      if (done || fail) begin
        if (sb.size() == 0) begin
          chk("unexpected_end", int'(done) * 1 + int'(fail) * 2, -1);
        end else begin
          e = sb.pop_front();
          chk("end_kind", done ? 1 : 2, e.kind);
          if (fail) chk("shortfall", int'(shortfall), e.val);
          chk("end_remain", int'(remain10) * 10 + int'(remain1), e.rem);
        end
      end
    end
  end

  task automatic wait_end(output int idx, output bit got);
    idx = 0;
    got = 1'b0;
    while (!got && idx < 600) begin
      @(negedge clk);
      idx++;
      if (done || fail) got = 1'b1;
    end
    if (!got) chk("end_timeout", 0, 1);
  endtask

  task automatic run(input int amt, input bit do_refill, input bit chk_lat);
    int  n_coins, idx;
    bit  got, was_fail;
    @(posedge clk); #1;
    start  = 1'b1;
    amount = 6'(amt);
    refill = do_refill;
    model_push(amt, n_coins);
    @(posedge clk); #1;
    start  = 1'b0;
    refill = 1'b0;
    wait_end(idx, got);
    was_fail = fail;
    if (got && chk_lat) chk("latency", idx, (amt == 0) ? 1 : 2 * n_coins + 2);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    chk("stock_empty", int'(stock_empty), model_empty());
    $display("txn amount=%0d coins=%0d %s shortfall=%0d cycles=%0d",
             amt, n_coins, was_fail ? "fail" : "done", shortfall, idx);
    sb.delete();
  endtask

  task automatic do_refill();
    @(posedge clk); #1 refill = 1'b1;
    @(posedge clk); #1 refill = 1'b0;
    for (int i = 0; i < 4; i++) stock_m[i] = 15;
    chk("refill_empty", int'(stock_empty), 0);
    $display("txn refill");
  endtask

  initial begin
    int  idx, n;
    bit  got;
    for (int i = 0; i < 4; i++) stock_m[i] = 4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_coin_val", int'(coin_val), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_remain", int'(remain10) * 10 + int'(remain1), 0);
    chk("rst_stock_empty", int'(stock_empty), 0);

    run(37, 1'b0, 1'b1);
    run(0, 1'b0, 1'b1);
    repeat (3) run(20, 1'b0, 1'b1);
    run(25, 1'b0, 1'b1);
    chk("empty20_after_25", int'(stock_empty[3]), 1);
    run(10, 1'b0, 1'b1);
    run(5, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1);
    run(8, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("shortfall_hold", int'(shortfall), 3);
    end
    run(4, 1'b1, 1'b1);
    chk("refill_dropped", int'(stock_empty), 15);
    do_refill();

    // Stall: coin 10 held for 6 cycles, a start during busy is ignored.
    ready_mode = 2;
    @(posedge clk); #1;
    start = 1'b1; amount = 6'd11;
    model_push(11, n);
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    while (!coin_valid && idx < 10) begin @(negedge clk); idx++; end
    chk("stall_valid_seen", int'(coin_valid), 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start  = (k == 2);
      amount = 6'd5;
      @(negedge clk);
      chk("stall_coin_val", int'(coin_val), 10);
      chk("stall_busy", int'(busy), 1);
    end
    start = 1'b0;
    ready_mode = 0;
    wait_end(idx, got);
    @(posedge clk); #1;
    chk("stall_sb_drained", sb.size(), 0);
    chk("stall_stock_empty", int'(stock_empty), model_empty());
    $display("txn amount=11 stalled coins=%0d", n);
    sb.delete();

    // Asynchronous reset mid-ISSUE.
    @(posedge clk); #1;
    start = 1'b1; amount = 6'd30;
    model_push(30, n);
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    while (!coin_valid && idx < 10) begin @(negedge clk); idx++; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_coin_valid", int'(coin_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_coin_val", int'(coin_val), 0);
    sb.delete();
    for (int i = 0; i < 4; i++) stock_m[i] = 4;
    $display("txn reset during amount=30");
    @(posedge clk); #1 rst_n = 1'b1;
    chk("arst_stock_empty", int'(stock_empty), 0);
    run(6, 1'b0, 1'b1);

    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) do_refill();
      run(int'($urandom_range(0, 63)), 1'($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential change-dispensing engine for the vending machine. It takes the refund/change amount produced by the payment stage and issues it to the coin mechanism one coin at a time over a valid/ready handshake. It chooses denominations greedily from 20/10/5/1, tracks per-denomination coin stock, and reports either completion or the shortfall it could not pay out.

## Interface
- `STOCK_W`, default 4: width of each per-denomination stock counter.
- `INIT_STOCK`, default 4: stock loaded into every denomination on reset.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request to dispense `amount`; sampled only in IDLE.
- `amount` in 6: change to pay, in yuan, 0–63.
- `refill` in 1: sets every stock counter to 2^STOCK_W−1; honoured only in IDLE.
- `coin_ready` in 1: the mechanism accepts `coin_val` on a clock edge where `coin_valid` and `coin_ready` are both high.
- `coin_valid` out 1: a coin is being offered.
- `coin_val` out 5: denomination offered (20, 10, 5 or 1); 0 when `coin_valid` is low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the full amount has been paid.
- `fail` out 1: one-cycle pulse when stock runs out before the amount is covered.
- `shortfall` out 6: unpaid remainder latched on fail; cleared to 0 on the next accepted start.
- `remain10` out 4, `remain1` out 4: tens and ones decimal digits of the live remaining amount, for the 7-seg display.
- `stock_empty` out 4: bit3..0 indicate that the 20/10/5/1 stock is 0.

## Operation
- States: IDLE, SELECT, ISSUE, DONE, FAIL.
- **IDLE**
  - A `start` with `amount`>0 latches `remain`=`amount`, clears `shortfall`, and moves to SELECT.
  - A `start` with `amount`==0 moves to DONE.
  - `refill` without `start` reloads the stocks. If `refill` and `start` arrive together, `start` wins and `refill` is dropped.
- **SELECT** (exactly one cycle)
  - If `remain`==0, go to DONE.
  - Otherwise pick the largest d in {20,10,5,1} with d≤`remain` and stock[d]>0, register `coin_val`=d, and go to ISSUE.
  - If no such d exists, go to FAIL.
- **ISSUE**
  - `coin_valid`=1 and `coin_val` is held stable until the handshake.
  - On the handshake: `remain`−=d, stock[d]−=1, go to SELECT.
  - With `coin_ready` low the block stays in ISSUE indefinitely.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **FAIL**: `fail`=1 for one cycle and `shortfall`=`remain`, then IDLE. `shortfall` holds until the next accepted start.
- `start` and `refill` are ignored while `busy`.
- Arithmetic:
  - `remain` is 6-bit unsigned and can never underflow, because d≤`remain` is guaranteed by SELECT.
  - Stock counters never decrement below 0; SELECT skips denominations with zero stock.
  - `remain10` = `remain`/10 and `remain1` = `remain`%10, both combinational from the `remain` register.
- Greedy fallback: when a large denomination is out of stock, smaller ones are used (e.g. 25 with stock20=0 pays 10,10,5).

## Timing
- Reset values:
  - State IDLE; `coin_valid`, `done`, `fail`, `busy` = 0.
  - `coin_val`, `shortfall`, `remain` = 0, so `remain10` = `remain1` = 0.
  - All stocks = INIT_STOCK; `stock_empty` = 0 when INIT_STOCK>0.
- Latency, with `start` sampled at edge E0:
  - SELECT occupies the cycle after E0.
  - The first `coin_valid` is high after E1.
  - With `coin_ready` held high, each coin costs 2 cycles.
  - For N coins, `done` is high in the cycle after edge E(2N+1).
- Zero amount: `done` is high in the cycle after E0, with no coins offered.
- `coin_val` and `coin_valid` are registered outputs, with no combinational path from `coin_ready`.
- Reset asserted mid-ISSUE clears all outputs immediately (asynchronously). The partial payout is abandoned and stocks return to INIT_STOCK.
- `done` and `fail` are mutually exclusive and each lasts exactly one cycle.

## Test plan
- Amount 37, full stock (4 each), `coin_ready` tied high:
  - Coins 20,10,5,1,1 are offered in that order.
  - `done` is high in the cycle after E11.
  - Final stocks are 3,3,3,2.
  - `remain10`/`remain1` step through 3/7, 1/7, 0/7, 0/2, 0/1, 0/0.
- Amount 0 → `done` pulse one cycle after start, `coin_valid` never high, stocks unchanged.
- Amount 25 with the 20-stock forced to 0 (drain it first) → coins 10,10,5, then `done`; `stock_empty`[3]=1 throughout.
- Stocks drained to 1×5 and 0 of every other denomination, amount 8:
  - Coin 5 is paid, then `fail` pulses.
  - `shortfall`=3 and holds until the next start.
- Amount 11, `coin_ready` held low for 6 cycles after the first `coin_valid`:
  - `coin_val`=10 stays stable the whole time, with no stock change.
  - Release → 10 then 1 are paid, then `done`.
  - A `start` pulse during `busy` has no effect.
- Reset pulse during ISSUE of amount 30 → `coin_valid`=0 and `busy`=0 at once. After release, stocks are 4 each; a new start with amount 6 pays 5,1.
